// File: rtl/prbs_err_counter.sv
// PRBS bit-error counter: measures mismatches from an upstream LFSR checker
// over a window of locked, valid samples, tracking lock drops along the way.
module prbs_err_counter #(
  parameter int unsigned WINDOW_W = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [WINDOW_W-1:0] i_window,
  input  logic                i_valid,
  input  logic                i_match,
  input  logic                i_lock,
  output logic                o_busy,
  output logic                o_done,
  output logic [WINDOW_W-1:0] o_sample_count,
  output logic [CNT_W-1:0]    o_err_count,
  output logic [7:0]          o_lock_loss,
  output logic                o_sat
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t              state;
  logic [WINDOW_W-1:0] window_q;
  logic [WINDOW_W-1:0] sample_count;
  logic [CNT_W-1:0]    err_count;
  logic [7:0]          lock_loss;
  logic                sat;
  logic [WINDOW_W-1:0] sample_next;

  assign sample_next = sample_count + WINDOW_W'(1);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state        <= IDLE;
      window_q     <= '0;
      sample_count <= '0;
      err_count    <= '0;
      lock_loss    <= '0;
      sat          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            window_q     <= i_window;
            sample_count <= '0;
            err_count    <= '0;
            lock_loss    <= '0;
            sat          <= 1'b0;
            state        <= (i_window == '0) ? DONE : WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (i_lock) state <= MEASURE;
        end
        MEASURE: begin
          if (!i_lock) begin
            // Counts are kept across a drop so accumulation resumes on relock.
            if (lock_loss != 8'hFF) lock_loss <= lock_loss + 8'd1;
            state <= WAIT_LOCK;
          end else if (i_valid) begin
            sample_count <= sample_next;
            if (!i_match && err_count != ERR_MAX) begin
              err_count <= err_count + CNT_W'(1);
              if (err_count == ERR_MAX - CNT_W'(1)) sat <= 1'b1;
            end
            if (sample_next == window_q) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy         = (state == WAIT_LOCK) || (state == MEASURE);
  assign o_done         = (state == DONE);
  assign o_sample_count = sample_count;
  assign o_err_count    = err_count;
  assign o_lock_loss    = lock_loss;
  assign o_sat          = sat;

endmodule

// File: tb/tb_prbs_err_counter.sv
// Bench for prbs_err_counter: directed scenarios plus random traffic, each
// cycle compared against a transaction-level reference model.
module tb_prbs_err_counter;

  localparam int unsigned WINDOW_W = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int          ERR_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                i_rst = 1'b0;
  logic                i_start = 1'b0;
  logic [WINDOW_W-1:0] i_window = '0;
  logic                i_valid = 1'b0;
  logic                i_match = 1'b0;
  logic                i_lock = 1'b0;
  logic                o_busy;
  logic                o_done;
  logic [WINDOW_W-1:0] o_sample_count;
  logic [CNT_W-1:0]    o_err_count;
  logic [7:0]          o_lock_loss;
  logic                o_sat;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "init";

  // Reference model state
  bit m_waiting, m_measuring, m_done, m_sat;
  int m_win, m_sc, m_ec, m_ll;

  prbs_err_counter #(.WINDOW_W(WINDOW_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_window       (i_window),
    .i_valid        (i_valid),
    .i_match        (i_match),
    .i_lock         (i_lock),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_sample_count (o_sample_count),
    .o_err_count    (o_err_count),
    .o_lock_loss    (o_lock_loss),
    .o_sat          (o_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_sc = 0; m_ec = 0; m_ll = 0; m_sat = 0;
  endtask

  // Measurement rules applied once per rising edge to the inputs of that cycle.
  task automatic model_step(input bit rst, input bit start, input int win,
                            input bit v, input bit m, input bit l);
    if (rst) begin
      m_waiting = 0; m_measuring = 0; m_done = 0; m_win = 0;
      model_clear();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_waiting && !m_measuring) begin
      if (start) begin
        model_clear();
        m_win = win;
        if (win == 0) m_done = 1;
        else m_waiting = 1;
      end
    end else if (m_waiting) begin
      if (l) begin
        m_waiting = 0;
        m_measuring = 1;
      end
    end else begin
      if (!l) begin
        if (m_ll < 255) m_ll++;
        m_measuring = 0;
        m_waiting = 1;
      end else if (v) begin
        m_sc++;
        if (!m) begin
          if (m_ec < ERR_MAX) m_ec++;
          if (m_ec == ERR_MAX) m_sat = 1;
        end
        if (m_sc == m_win) begin
          m_measuring = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit start, input int win,
                      input bit v, input bit m, input bit l);
    i_rst = rst; i_start = start; i_window = win[WINDOW_W-1:0];
    i_valid = v; i_match = m; i_lock = l;
    model_step(rst, start, win, v, m, l);
    @(posedge clk);
    #1;
    check({phase, ".busy"}, int'(o_busy), int'(m_waiting || m_measuring));
    check({phase, ".done"}, int'(o_done), int'(m_done));
    check({phase, ".samples"}, int'(o_sample_count), m_sc);
    check({phase, ".errors"}, int'(o_err_count), m_ec);
    check({phase, ".lockloss"}, int'(o_lock_loss), m_ll);
    check({phase, ".sat"}, int'(o_sat), int'(m_sat));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    phase = "reset";
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 7, 1, 0, 1);
    check("reset.busy_zero", int'(o_busy), 0);
    check("reset.count_zero", int'(o_sample_count), 0);

    // Ten samples, mismatches at samples 3 and 7
    phase = "basic";
    step(0, 1, 10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) step(0, 0, 0, 1, (k != 3 && k != 7), 1);
    check("basic.done_pulse", int'(o_done), 1);
    check("basic.samples_10", int'(o_sample_count), 10);
    check("basic.errors_2", int'(o_err_count), 2);
    check("basic.lockloss_0", int'(o_lock_loss), 0);
    step(0, 0, 0, 1, 0, 1);
    check("basic.done_once", int'(o_done), 0);
    check("basic.hold_samples", int'(o_sample_count), 10);
    idle(2);

    // Lock drop in the middle of a 20-sample window
    phase = "lockdrop";
    step(0, 1, 20, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 15; k++) step(0, 1, 3, 1, 1, 1);
    check("lockdrop.done", int'(o_done), 1);
    check("lockdrop.lockloss_1", int'(o_lock_loss), 1);
    check("lockdrop.samples_20", int'(o_sample_count), 20);
    check("lockdrop.errors_0", int'(o_err_count), 0);
    idle(2);

    // Error counter saturation
    phase = "saturate";
    step(0, 1, 40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 40; k++) step(0, 0, 0, 1, 0, 1);
    check("saturate.errors_15", int'(o_err_count), 15);
    check("saturate.sat", int'(o_sat), 1);
    check("saturate.samples_40", int'(o_sample_count), 40);
    idle(2);
    check("saturate.sat_sticky", int'(o_sat), 1);

    // Zero window, then a start during a running measurement
    phase = "zerowin";
    step(0, 1, 0, 1, 0, 1);
    check("zerowin.done", int'(o_done), 1);
    check("zerowin.sat_cleared", int'(o_sat), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 9, 1, 1, 1);
    step(0, 1, 9, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    check("zerowin.restart_ignored_done", int'(o_done), 1);
    check("zerowin.restart_ignored_errs", int'(o_err_count), 1);
    idle(2);

    // Reset at sample 6 of 10, then a fresh full window
    phase = "midreset";
    step(0, 1, 10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 1);
    step(1, 1, 10, 1, 0, 1);
    check("midreset.busy_zero", int'(o_busy), 0);
    check("midreset.samples_zero", int'(o_sample_count), 0);
    check("midreset.errors_zero", int'(o_err_count), 0);
    step(0, 1, 10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 1, 1);
    check("midreset.fresh_done", int'(o_done), 1);
    check("midreset.fresh_samples", int'(o_sample_count), 10);
    idle(2);

    // Valid traffic while never locked
    phase = "nolock";
    step(0, 1, 5, 0, 0, 0);
    for (int k = 0; k < 50; k++) step(0, 0, 0, 1, 0, 0);
    check("nolock.busy", int'(o_busy), 1);
    check("nolock.samples_0", int'(o_sample_count), 0);
    check("nolock.no_done", int'(o_done), 0);
    step(1, 0, 0, 0, 0, 0);

    phase = "random";
    for (int k = 0; k < 4000; k++) begin
      bit r, s, v, m, l;
      int w;
      r = ($urandom_range(199) == 0);
      s = ($urandom_range(15) == 0);
      w = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(24, 1));
      v = ($urandom_range(9) < 7);
      m = ($urandom_range(9) < 7);
      l = ($urandom_range(19) != 0);
      step(r, s, w, v, m, l);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
